// File: rtl/ghost_limit_detector_pkg.sv
// ghost_limit_detector_pkg: shared lookup states, board constants and limit masking
package ghost_limit_detector_pkg;
  typedef enum logic [2:0] {IDLE, LATCH, RD_UP, RD_DN, RD_LT, RD_RT, COLLECT, UPDATE} state_t;
  localparam int H_BOARD_ON = 144;
  localparam int V_BOARD_ON = 35;
  localparam int TILE_SHIFT = 4;
  localparam int CENTER_OFFSET = 8;
  localparam int TILE_W = 5;
  localparam int UP = 3;
  localparam int DOWN = 2;
  localparam int LEFT = 1;
  localparam int RIGHT = 0;
  function automatic logic [3:0] mask_limits(input logic h_aligned, input logic v_aligned, input logic [3:0] wall);
    mask_limits = !h_aligned && !v_aligned ? 4'b1111 :
                  !h_aligned ? 4'b0011 :
                  !v_aligned ? 4'b1100 : ~wall;
  endfunction
endpackage

// File: rtl/ghost_limit_detector_tile_calc.sv
// ghost_tile_calc: combinational pixel position to tile coordinate and alignment
module ghost_tile_calc
  import ghost_limit_detector_pkg::*;
(
  input  logic [10:0]       h_pos,
  input  logic [9:0]        v_pos,
  output logic [TILE_W-1:0] h_tile,
  output logic [TILE_W-1:0] v_tile,
  output logic              h_aligned,
  output logic              v_aligned
);
  logic [10:0] dh;
  logic [9:0]  dv;
  // offsets from the board origin saturate at zero, then the center point selects the tile
  always_comb begin
    dh = h_pos >= 11'(H_BOARD_ON) ? h_pos - 11'(H_BOARD_ON) : '0;
    dv = v_pos >= 10'(V_BOARD_ON) ? v_pos - 10'(V_BOARD_ON) : '0;
    h_tile = TILE_W'((dh + 11'(CENTER_OFFSET)) >> TILE_SHIFT);
    v_tile = TILE_W'((dv + 10'(CENTER_OFFSET)) >> TILE_SHIFT);
    h_aligned = dh[TILE_SHIFT-1:0] == '0;
    v_aligned = dv[TILE_SHIFT-1:0] == '0;
  end
endmodule

// File: rtl/ghost_limit_detector.sv
// ghost_limit_detector: per-frame wall lookup around a ghost producing movement limits
module ghost_limit_detector
  import ghost_limit_detector_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync_enable,
  input  logic [10:0] ghost_h_pos,
  input  logic [9:0]  ghost_v_pos,
  output logic        maze_rd_en,
  output logic [9:0]  maze_addr,
  input  logic        maze_wall,
  output logic [4:0]  h_ghost_tile,
  output logic [4:0]  v_ghost_tile,
  output logic        up_limit,
  output logic        down_limit,
  output logic        left_limit,
  output logic        right_limit,
  output logic        limits_done
);
  state_t             state, state_nx;
  logic [10:0]        h_pos;
  logic [9:0]         v_pos;
  logic [TILE_W-1:0]  h_calc, v_calc, h_tile, v_tile;
  logic               h_al_calc, v_al_calc, h_al, v_al;
  logic [UP:LEFT]     wall;

  ghost_tile_calc u_tile_calc (
    .h_pos(h_pos),
    .v_pos(v_pos),
    .h_tile(h_calc),
    .v_tile(v_calc),
    .h_aligned(h_al_calc),
    .v_aligned(v_al_calc)
  );

  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;

  // sequence advances one state per cycle once started; reads issue in up, down, left, right order
  always_comb begin
    state_nx = state == IDLE && !vsync_enable ? IDLE : state_t'(state + 3'd1);
    maze_rd_en = state inside {RD_UP, RD_DN, RD_LT, RD_RT};
    maze_addr = state == RD_UP ? {v_tile - 5'd1, h_tile} :
                state == RD_DN ? {v_tile + 5'd1, h_tile} :
                state == RD_LT ? {v_tile, h_tile - 5'd1} :
                state == RD_RT ? {v_tile, h_tile + 5'd1} : '0;
  end

  // latch lookup inputs, collect wall bits one cycle after each read, publish on entry to UPDATE
  always_ff @(posedge clk) begin
    if (reset) begin
      h_pos <= '0;
      v_pos <= '0;
      h_tile <= '0;
      v_tile <= '0;
      h_al <= 1'b0;
      v_al <= 1'b0;
      wall <= '0;
      h_ghost_tile <= '0;
      v_ghost_tile <= '0;
      {up_limit, down_limit, left_limit, right_limit} <= '0;
      limits_done <= 1'b0;
    end else begin
      if (state == IDLE && vsync_enable) begin
        h_pos <= ghost_h_pos;
        v_pos <= ghost_v_pos;
      end
      if (state == LATCH) begin
        h_tile <= h_calc;
        v_tile <= v_calc;
        h_al <= h_al_calc;
        v_al <= v_al_calc;
      end
      if (state == RD_DN) wall[UP] <= maze_wall || v_tile == '0;
      if (state == RD_LT) wall[DOWN] <= maze_wall || v_tile == '1;
      if (state == RD_RT) wall[LEFT] <= maze_wall;
      if (state == COLLECT) begin
        {up_limit, down_limit, left_limit, right_limit} <= mask_limits(h_al, v_al, {wall, maze_wall});
        h_ghost_tile <= h_tile;
        v_ghost_tile <= v_tile;
      end
      limits_done <= state == COLLECT;
    end
  end
endmodule

// File: tb/tb_ghost_limit_detector.sv
// tb_ghost_limit_detector: randomized lookups against an arithmetic tile/wall model
module tb_ghost_limit_detector;
  logic        clk = 1'b0;
  logic        reset, vsync_enable;
  logic [10:0] ghost_h_pos;
  logic [9:0]  ghost_v_pos;
  logic        maze_rd_en, maze_wall;
  logic [9:0]  maze_addr;
  logic [4:0]  h_ghost_tile, v_ghost_tile;
  logic        up_limit, down_limit, left_limit, right_limit, limits_done;
  logic        rom [1024];
  int          total = 0, bad = 0;
  logic [3:0]  cur_lim = '0;
  int          cur_h = 0, cur_v = 0;

  always #5 clk = ~clk;

  ghost_limit_detector dut (
    .clk(clk),
    .reset(reset),
    .vsync_enable(vsync_enable),
    .ghost_h_pos(ghost_h_pos),
    .ghost_v_pos(ghost_v_pos),
    .maze_rd_en(maze_rd_en),
    .maze_addr(maze_addr),
    .maze_wall(maze_wall),
    .h_ghost_tile(h_ghost_tile),
    .v_ghost_tile(v_ghost_tile),
    .up_limit(up_limit),
    .down_limit(down_limit),
    .left_limit(left_limit),
    .right_limit(right_limit),
    .limits_done(limits_done)
  );

  // wall ROM: data valid one cycle after a read, garbage otherwise
  always @(posedge clk) maze_wall <= maze_rd_en ? rom[maze_addr] : 1'($urandom);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill_rom(input int pct);
    for (int i = 0; i < 1024; i++) rom[i] = $urandom_range(99) < pct;
  endtask

  task automatic lookup(input int h, input int v, input int strobe_at, input int reset_at);
    int dh, dv, ht, vt;
    int a[4];
    bit ha, va, r;
    logic [3:0] w, lim;
    dh = h >= 144 ? h - 144 : 0;
    dv = v >= 35 ? v - 35 : 0;
    ht = ((dh + 8) / 16) % 32;
    vt = ((dv + 8) / 16) % 32;
    ha = dh % 16 == 0;
    va = dv % 16 == 0;
    a[0] = ((vt + 31) % 32) * 32 + ht;
    a[1] = ((vt + 1) % 32) * 32 + ht;
    a[2] = vt * 32 + (ht + 31) % 32;
    a[3] = vt * 32 + (ht + 1) % 32;
    w = {vt == 0 || rom[a[0]], vt == 31 || rom[a[1]], rom[a[2]], rom[a[3]]};
    if (!ha && !va) lim = 4'b1111;
    else if (!ha) lim = 4'b0011;
    else if (!va) lim = 4'b1100;
    else lim = ~w;
    @(negedge clk);
    ghost_h_pos = 11'(h);
    ghost_v_pos = 10'(v);
    vsync_enable = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      r = reset_at != 0 && c > reset_at;
      if (r) begin
        cur_lim = '0;
        cur_h = 0;
        cur_v = 0;
      end else if (c == 7) begin
        cur_lim = lim;
        cur_h = ht;
        cur_v = vt;
      end
      chk("rd_en", maze_rd_en, !r && c >= 2 && c <= 5);
      if (!r && c >= 2 && c <= 5) chk($sformatf("addr%0d", c - 2), maze_addr, a[c - 2]);
      if (r && c == reset_at + 1) chk("addr_rst", maze_addr, 0);
      chk("done", limits_done, !r && c == 7);
      chk("limits", {up_limit, down_limit, left_limit, right_limit}, cur_lim);
      chk("h_tile", h_ghost_tile, cur_h);
      chk("v_tile", v_ghost_tile, cur_v);
      vsync_enable = c == strobe_at;
      reset = c == reset_at;
      ghost_h_pos = 11'($urandom);
      ghost_v_pos = 10'($urandom);
    end
    vsync_enable = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    int h, v, s, rs;
    reset = 1'b1;
    vsync_enable = 1'b0;
    ghost_h_pos = '0;
    ghost_v_pos = '0;
    fill_rom(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_limits", {up_limit, down_limit, left_limit, right_limit}, 0);
    chk("rst_tiles", {h_ghost_tile, v_ghost_tile}, 0);
    chk("rst_rd_en", maze_rd_en, 0);
    chk("rst_addr", maze_addr, 0);
    chk("rst_done", limits_done, 0);
    reset = 1'b0;
    lookup(224, 83, 0, 0);
    rom[69] = 1'b1;
    rom[133] = 1'b1;
    lookup(224, 83, 0, 0);
    fill_rom(50);
    lookup(230, 83, 0, 0);
    lookup(224, 90, 0, 0);
    fill_rom(0);
    lookup(144, 35, 0, 0);
    lookup(640, 531, 0, 0);
    lookup(100, 20, 0, 0);
    fill_rom(30);
    lookup(224, 83, 3, 0);
    lookup(224, 83, 7, 0);
    lookup(224, 83, 0, 4);
    lookup(240, 99, 0, 0);
    for (int i = 0; i < 60; i++) begin
      if (i % 8 == 0) fill_rom($urandom_range(10, 70));
      h = $urandom_range(1) ? 144 + 16 * $urandom_range(31) : $urandom_range(100, 700);
      v = $urandom_range(1) ? 35 + 16 * $urandom_range(31) : $urandom_range(20, 560);
      rs = $urandom_range(9) == 0 ? $urandom_range(1, 8) : 0;
      s = rs == 0 && $urandom_range(3) == 0 ? $urandom_range(1, 7) : 0;
      lookup(h, v, s, rs);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ghost_limit_detector.md
Name: ghost_limit_detector

Overview:
- Supplies one ghost controller with its movement-permission flags (up/down/left/right limit) and its current tile coordinates.
- Once per frame it reads the maze wall map around the ghost's position and registers the results.
- It sits between the maze wall ROM and a ghost controller, which consumes these signals in the next vsync-gated movement step.
- Limit = 1 means movement in that direction is allowed; limit = 0 means blocked.

Parameters:
- H_BOARD_ON, 144, horizontal pixel where tile column 0 starts.
- V_BOARD_ON, 35, vertical line where tile row 0 starts.
- TILE_SHIFT, 4, log2 of tile size in pixels (16-pixel tiles).
- CENTER_OFFSET, 8, pixel offset from the ghost's top-left corner to the point used for tile lookup.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- vsync_enable  in  1  one-cycle per-frame strobe that starts a lookup
- ghost_h_pos  in  11  ghost top-left horizontal counter
- ghost_v_pos  in  10  ghost top-left vertical counter
- maze_rd_en  out  1  wall ROM read strobe
- maze_addr  out  10  wall ROM address, {v_tile, h_tile}
- maze_wall  in  1  ROM data, 1 = wall; valid exactly 1 cycle after maze_rd_en
- h_ghost_tile  out  5  registered tile column
- v_ghost_tile  out  5  registered tile row
- up_limit, down_limit, left_limit, right_limit  out  1 each  1 = move allowed
- limits_done  out  1  one-cycle pulse when new outputs take effect

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; all four limits = 0; tiles = 0; maze_rd_en = 0; maze_addr = 0; limits_done = 0.
  - Reset asserted mid-lookup abandons the lookup; outputs take reset values on the next edge.
- Tile math:
  - dh = ghost_h_pos - H_BOARD_ON, saturating at 0; dv likewise from ghost_v_pos and V_BOARD_ON.
  - h_tile = (dh + CENTER_OFFSET) >> TILE_SHIFT, truncated to 5 bits; v_tile likewise.
  - h_aligned = (dh[TILE_SHIFT-1:0] == 0); v_aligned likewise.
- State machine: IDLE -> LATCH -> RD_UP -> RD_DN -> RD_LT -> RD_RT -> COLLECT -> UPDATE -> IDLE.
  - Let T be the cycle in which vsync_enable is sampled high in IDLE.
  - LATCH (T+1): position, tiles and alignment are registered. Position changes after T are ignored for this lookup.
  - RD_* (T+2..T+5): maze_rd_en = 1 with addresses in this order:
    - up: {v-1, h}
    - down: {v+1, h}
    - left: {v, h-1}
    - right: {v, h+1}
  - Wall bits are captured T+3..T+6.
  - UPDATE (T+7): outputs are registered and limits_done = 1 for exactly this cycle.
- Wrap rules:
  - Horizontal neighbours wrap modulo 32 (tunnel): h=0 left reads column 31; h=31 right reads column 0.
  - Vertical out of range (v=0 up, v=31 down): the read is still issued (address wraps) but the result is forced to wall.
- Alignment masking, applied at UPDATE:
  - If !h_aligned: up_limit = down_limit = 0; left_limit = right_limit = 1 (mid-tile motion continues).
  - If !v_aligned: left_limit = right_limit = 0; up_limit = down_limit = 1.
  - If neither axis is aligned: all four limits = 1. This is a fault condition; the controller never produces it.
  - If both are aligned: each limit = !wall bit.
- vsync_enable while not IDLE is ignored; no queuing. A strobe at exactly UPDATE is also ignored.
- Outputs hold their values between UPDATE events.
- maze_rd_en is 0 in every state other than RD_*.

Decomposition:
- Shared package/header holds:
  - state encodings (3-bit: IDLE, LATCH, RD_UP, RD_DN, RD_LT, RD_RT, COLLECT, UPDATE);
  - board origin and tile constants alongside the existing board macros;
  - direction indices UP=3, DOWN=2, LEFT=1, RIGHT=0, matching ghost state numbering.
- One sub-module is natural: ghost_tile_calc, a combinational position-to-tile/alignment unit, reused by the pacman and other ghost detectors.

Test Plan:
1. Open 4-way junction:
   - Stimulus: h_pos=224, v_pos=83 (tile 5,3, aligned); ROM all zero around it; vsync_enable at T.
   - Required: maze_addr = 69, 133, 100, 102 at T+2..T+5; at T+7 all limits = 1, h_tile=5, v_tile=3, limits_done=1 for one cycle.
2. Corridor walls:
   - Stimulus: same position; ROM walls at addresses 69 and 133.
   - Required: up=0, down=0, left=1, right=1.
3. Mid-tile horizontal:
   - Stimulus: h_pos=230, v_pos=83.
   - Required: up=0, down=0, left=1, right=1, regardless of ROM contents.
4. Tunnel and edge:
   - Stimulus: h_pos=144, v_pos=35 (tile 0,0).
   - Required: left read address = 31; up forced to wall (up=0) even if ROM bit = 0.
5. Busy strobe and reset:
   - Stimulus: second vsync_enable at T+3.
   - Required: no restart; exactly one limits_done, at T+7.
   - Stimulus: reset at T+4.
   - Required: IDLE next cycle, all limits = 0, no limits_done.
